// File: rtl/fxp_pkg.sv
// Shared definitions for the sequential fixed-point multiplier:
// controller state encoding and operand/product width helpers.
package fxp_pkg;

  // Controller states of the shift-and-add multiplier
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fxp_state_t;

  // Default operand format is Q8.8
  localparam int unsigned FXP_DEF_INT  = 8;
  localparam int unsigned FXP_DEF_FRAC = 8;

  // Operand width N from the integer and fraction bit counts
  function automatic int unsigned fxp_op_w(input int unsigned int_bits,
                                           input int unsigned frac_bits);
    return int_bits + frac_bits;
  endfunction

  // Full-precision product width 2N for an N-bit operand
  function automatic int unsigned fxp_prod_w(input int unsigned op_bits);
    return 2 * op_bits;
  endfunction

endpackage

// File: rtl/fxp_abs.sv
// Combinational sign/magnitude split of a two's-complement value.
// The magnitude is returned as an unsigned value of the same width, so
// the most negative input maps to 2^(WIDTH-1) without overflowing.
module fxp_abs
  import fxp_pkg::*;
#(
  parameter int unsigned WIDTH = fxp_op_w(FXP_DEF_INT, FXP_DEF_FRAC)
) (
  input  logic [WIDTH-1:0] value,
  output logic             sign,
  output logic [WIDTH-1:0] mag
);

  // Negate only when the sign bit is set; the unsigned reading of the
  // negated most-negative value is exactly its magnitude.
  always_comb begin
    sign = value[WIDTH-1];
    mag  = sign ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;
  end

endmodule

// File: rtl/fxp_mul_seq.sv
// Sequential signed fixed-point multiplier (shift-and-add, one bit of
// |b| per clock). Operands are Q(int).(frac), the product is the full
// 2N-bit Q(2*int).(2*frac) value, with no rounding or saturation.
// Optional build macro FXP_MUL_EARLY_TERM_EN: finish as soon as the
// remaining bits of |b| are all zero instead of always taking N cycles.
module fxp_mul_seq
  import fxp_pkg::*;
#(
  parameter int unsigned input_width_int  = FXP_DEF_INT,
  parameter int unsigned input_width_frac = FXP_DEF_FRAC
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       in_valid,
  output logic                                                       in_ready,
  input  logic [fxp_op_w(input_width_int, input_width_frac)-1:0]     in_a,
  input  logic [fxp_op_w(input_width_int, input_width_frac)-1:0]     in_b,
  output logic                                                       out_valid,
  input  logic                                                       out_ready,
  output logic [fxp_prod_w(fxp_op_w(input_width_int, input_width_frac))-1:0] out_data
);

  localparam int unsigned N  = fxp_op_w(input_width_int, input_width_frac);
  localparam int unsigned P  = fxp_prod_w(N);
  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  fxp_state_t     state;
  logic           sign_q;
  logic [N-1:0]   mag_a_q;
  logic [N-1:0]   mag_b_q;
  logic [P-1:0]   acc_q;
  logic [CW-1:0]  cnt_q;

  logic           a_sign;
  logic           b_sign;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;

  logic [N-1:0]   b_rem;
  logic [P-1:0]   partial;
  logic [P-1:0]   acc_next;
  logic           finish;

  fxp_abs #(.WIDTH(N)) u_abs_a (
    .value (in_a),
    .sign  (a_sign),
    .mag   (a_mag)
  );

  fxp_abs #(.WIDTH(N)) u_abs_b (
    .value (in_b),
    .sign  (b_sign),
    .mag   (b_mag)
  );

  // Next accumulator value for the current bit of |b|, plus the decision
  // whether this BUSY edge is the last one.
  always_comb begin
    b_rem    = mag_b_q >> cnt_q;
    partial  = b_rem[0] ? ({{N{1'b0}}, mag_a_q} << cnt_q) : '0;
    acc_next = acc_q + partial;
`ifdef FXP_MUL_EARLY_TERM_EN
    finish   = ((b_rem >> 1) == '0);
`else
    finish   = (cnt_q == LAST_BIT);
`endif
  end

  // Controller: accept operands in IDLE, iterate in BUSY, hold the result
  // in DONE until the consumer takes it. Reset wins over every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      sign_q    <= 1'b0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_q   <= a_sign ^ b_sign;
            mag_a_q  <= a_mag;
            mag_b_q  <= b_mag;
            acc_q    <= '0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CW'(1);
          if (finish) begin
            out_data  <= sign_q ? (~acc_next + {{(P-1){1'b0}}, 1'b1}) : acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_mul_seq.sv
// Self-checking bench for fxp_mul_seq (Q8.8): directed cases, stall and
// mid-operation reset, then randomized operands against an arithmetic
// reference product and latency.
module tb_fxp_mul_seq;

  localparam int N = 16;
  localparam int P = 32;
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] out_data;

  int tests_run = 0;
  int tests_failed = 0;

  fxp_mul_seq #(.input_width_int(8), .input_width_frac(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product: plain signed multiplication of the operand values
  function automatic logic [P-1:0] refProduct(input logic [N-1:0] a, input logic [N-1:0] b);
    longint va, vb, prod;
    va   = longint'($signed(a));
    vb   = longint'($signed(b));
    prod = va * vb;
    return prod[P-1:0];
  endfunction

  // Reference latency in edges from acceptance to out_valid
  function automatic int refLatency(input logic [N-1:0] b);
`ifdef FXP_MUL_EARLY_TERM_EN
    longint vb;
    int hi;
    vb = longint'($signed(b));
    if (vb < 0) vb = -vb;
    if (vb == 0) return 1;
    hi = 0;
    for (int i = 0; i <= N; i++) if (vb >= (longint'(1) << i)) hi = i;
    return hi + 1;
`else
    return N;
`endif
  endfunction

  // Offer one operand pair, wait for the result, optionally stall the
  // consumer for 'stall' cycles, then release it and check the handoff.
  task automatic applyStimulus(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                               input int stall);
    int waited;
    int lat;
    logic [P-1:0] exp;
    exp = refProduct(a, b);
    waited = 0;
    while (in_ready !== 1'b1 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= TIMEOUT) checkOutput({tag, "_ready_timeout"}, 64'(waited), 64'(0));
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    checkOutput({tag, "_busy_in_ready"}, 64'(in_ready), 64'(0));
    lat = 0;
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      if (lat == 3) begin
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput({tag, "_latency"}, 64'(lat), 64'(refLatency(b)));
    checkOutput({tag, "_data"}, 64'(out_data), 64'(exp));
    for (int s = 0; s < stall; s++) begin
      in_valid = s[0];
      in_a = $urandom;
      in_b = $urandom;
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
      checkOutput({tag, "_hold_data"}, 64'(out_data), 64'(exp));
      checkOutput({tag, "_hold_in_ready"}, 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_release_valid"}, 64'(out_valid), 64'(0));
    checkOutput({tag, "_release_in_ready"}, 64'(in_ready), 64'(1));
    checkOutput({tag, "_release_data"}, 64'(out_data), 64'(exp));
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    int sel;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_out_data", 64'(out_data), 64'(0));

    applyStimulus("q_3p5x2p25", 16'h0380, 16'h0240, 0);
    applyStimulus("q_m1p5x2", 16'hFE80, 16'h0200, 2);
    applyStimulus("q_minxmin", 16'h8000, 16'h8000, 5);
    applyStimulus("q_b_zero", 16'h1234, 16'h0000, 1);
    applyStimulus("q_bmin", 16'h0001, 16'h8000, 0);
    applyStimulus("q_neg_neg", 16'hFFFF, 16'hFFFF, 0);

    // Reset in the middle of a product: accept, then assert rst at BUSY edge 7
    in_valid = 1'b1;
    in_a = 16'h7FFF;
    in_b = 16'h7FFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_in_ready", 64'(in_ready), 64'(1));
    checkOutput("midreset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midreset_out_data", 64'(out_data), 64'(0));
    applyStimulus("after_reset", 16'h0100, 16'h0100, 0);

    // Randomized operands, with extremes mixed in
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 7);
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) ra = 16'h8000;
      if (sel == 1) rb = 16'h8000;
      if (sel == 2) rb = rb & 16'h000F;
      if (sel == 3) rb = 16'h0000;
      applyStimulus("rand", ra, rb, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fxp_mul_seq.md
FXP_MUL_SEQ -- requirements
Module: fxp_mul_seq

Interface
REQ-001 SHALL have parameter input_width_int, default 8, operand integer bits including sign (>=1).
REQ-002 SHALL have parameter input_width_frac, default 8, operand fraction bits (>=0); N = input_width_int+input_width_frac, N>=2.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, operand handshake.
REQ-006 SHALL have ports in_a input N and in_b input N, signed two's-complement operands in Q(input_width_int).(input_width_frac).
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1, result handshake.
REQ-008 SHALL have port out_data output 2N, signed full-precision product in Q(2*input_width_int).(2*input_width_frac), directly consumable by the width-conversion stage.

Function
REQ-009 SHALL implement FSM with states IDLE, BUSY, DONE.
REQ-010 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-011 SHALL, on an edge with in_valid&in_ready, latch sign=in_a[N-1]^in_b[N-1], |in_a| and |in_b| as N-bit unsigned values, clear accumulator and iteration counter, and go to BUSY.
REQ-012 SHALL treat the most negative operand as magnitude 2^(N-1) without overflow.
REQ-013 SHALL, per BUSY edge, add |a|<<i to the 2N-bit accumulator when bit i of |b| is 1, then increment i.
REQ-014 SHALL, on the edge completing iteration N-1, write out_data = sign ? -acc : acc and enter DONE; latency = N edges after acceptance.
REQ-015 SHALL never overflow: all products, including (-2^(N-1))^2, fit the 2N-bit signed result; no saturation or rounding is performed.
REQ-016 SHALL hold out_data and out_valid stable in DONE until an edge with out_ready=1, then enter IDLE; a new operand is accepted no earlier than the following edge.
REQ-017 SHALL ignore in_valid, in_a and in_b outside IDLE.
REQ-018 SHALL keep out_data unchanged after leaving DONE until the next result is written.

Reset
REQ-019 SHALL, on any edge with rst=1 (including mid-BUSY or in DONE), enter IDLE, clear out_data, accumulator, counter and sign, abandon any in-flight product, and give rst priority over all handshakes.
REQ-020 SHALL present in_ready=1, out_valid=0, out_data=0 in the cycle after reset.

Configuration
REQ-021 SHALL, with macro FXP_MUL_EARLY_TERM_EN defined, finish BUSY on the edge where all unprocessed bits of |b| are zero, writing the result and entering DONE on that edge (minimum 1 BUSY edge; b=0 gives latency 1).
REQ-022 SHALL, without FXP_MUL_EARLY_TERM_EN, always take exactly N BUSY edges regardless of operand values; the product value is identical in both builds.

Structure
REQ-023 SHALL place the FSM state enum and the N/2N width helper constants in shared package fxp_pkg.
REQ-024 SHALL use one sub-module, fxp_abs (combinational sign/magnitude split), instantiated for in_a and in_b.

Verification
REQ-025 Q8.8: in_a=0x0380 (3.5), in_b=0x0240 (2.25) -> out_data=0x0007E000 (7.875), out_valid 16 edges after acceptance (macro off).
REQ-026 in_a=0xFE80 (-1.5), in_b=0x0200 (2.0) -> out_data=0xFFFD0000 (-3.0).
REQ-027 in_a=0x8000, in_b=0x8000 -> out_data=0x40000000 (+16384.0), no wrap.
REQ-028 out_ready held 0 for 5 cycles in DONE -> out_data and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-029 rst=1 at BUSY edge 7 -> next cycle in_ready=1, out_valid=0, out_data=0; new operands 0x0100x0100 -> 0x00010000.
REQ-030 in_b=0x0000 with FXP_MUL_EARLY_TERM_EN -> out_valid after 1 edge, out_data=0; without macro -> after 16 edges, out_data=0.
